// File: rtl/llc_mem_bridge.sv
// Bridge between llc_core line requests/responses and a beat-oriented burst memory port.
// Optional LLC_MEM_BRIDGE_STATS_EN adds saturating read/write completion counters.
module llc_mem_bridge #(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH,
  localparam int OFF       = $clog2(LINE_WIDTH / 8),
  localparam int LADDR_W   = ADDR_WIDTH - OFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  llc_mem_req_valid,
  output logic                  llc_mem_req_ready,
  input  logic                  llc_mem_req_hwrite,
  input  logic [1:0]            llc_mem_req_hprot,
  input  logic [LADDR_W-1:0]    llc_mem_req_addr,
  input  logic [LINE_WIDTH-1:0] llc_mem_req_line,
  output logic                  llc_mem_rsp_valid,
  input  logic                  llc_mem_rsp_ready,
  output logic [LINE_WIDTH-1:0] llc_mem_rsp_line,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_write,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [7:0]            mem_cmd_len,
  output logic [1:0]            mem_cmd_prot,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  output logic                  mem_wdata_last,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_last,
`ifdef LLC_MEM_BRIDGE_STATS_EN
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_wr_cnt,
`endif
  output logic                  proto_err
);

  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RSP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  hwrite_q;
  logic [1:0]            hprot_q;
  logic [LADDR_W-1:0]    addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] rbuf_q;
  logic                  proto_err_q;

  logic req_fire, wr_fire, rd_fire, rsp_fire, cnt_last;

  assign cnt_last = (cnt_q == LAST_CNT);
  assign req_fire = llc_mem_req_valid && llc_mem_req_ready;
  assign wr_fire  = mem_wdata_valid && mem_wdata_ready;
  assign rd_fire  = mem_rdata_valid && mem_rdata_ready;
  assign rsp_fire = llc_mem_rsp_valid && llc_mem_rsp_ready;

  assign mem_cmd_write    = hwrite_q;
  assign mem_cmd_addr     = {addr_q, {OFF{1'b0}}};
  assign mem_cmd_len      = 8'(BEATS - 1);
  assign mem_cmd_prot     = hprot_q;
  assign mem_wdata        = line_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
  assign mem_wdata_last   = cnt_last;
  assign llc_mem_rsp_line = rbuf_q;
  assign proto_err        = proto_err_q;

  // Valids depend on state only, so no ready input reaches a valid output.
  always_comb begin
    state_d           = state_q;
    llc_mem_req_ready = 1'b0;
    mem_cmd_valid     = 1'b0;
    mem_wdata_valid   = 1'b0;
    mem_rdata_ready   = 1'b0;
    llc_mem_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        llc_mem_req_ready = 1'b1;
        if (llc_mem_req_valid) state_d = CMD;
      end
      CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = hwrite_q ? WDATA : RDATA;
      end
      WDATA: begin
        mem_wdata_valid = 1'b1;
        if (mem_wdata_ready && cnt_last) state_d = IDLE;
      end
      RDATA: begin
        mem_rdata_ready = 1'b1;
        if (mem_rdata_valid && cnt_last) state_d = RSP;
      end
      RSP: begin
        llc_mem_rsp_valid = 1'b1;
        if (llc_mem_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hwrite_q    <= 1'b0;
      hprot_q     <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      rbuf_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        hwrite_q <= llc_mem_req_hwrite;
        hprot_q  <= llc_mem_req_hprot;
        addr_q   <= llc_mem_req_addr;
        line_q   <= llc_mem_req_line;
        cnt_q    <= '0;
      end
      if (wr_fire) cnt_q <= cnt_q + 1'b1;
      // Beat placement follows the internal count even when the last marker disagrees.
      if (rd_fire) begin
        rbuf_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
        cnt_q <= cnt_q + 1'b1;
        if (mem_rdata_last != cnt_last) proto_err_q <= 1'b1;
      end
    end
  end

`ifdef LLC_MEM_BRIDGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (rsp_fire && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (wr_fire && cnt_last && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
    end
  end
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Directed self-checking bench for llc_mem_bridge with default 128/64/32 parameters.
module tb_llc_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         llc_mem_req_valid;
  logic         llc_mem_req_ready;
  logic         llc_mem_req_hwrite;
  logic [1:0]   llc_mem_req_hprot;
  logic [27:0]  llc_mem_req_addr;
  logic [127:0] llc_mem_req_line;
  logic         llc_mem_rsp_valid;
  logic         llc_mem_rsp_ready;
  logic [127:0] llc_mem_rsp_line;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_write;
  logic [31:0]  mem_cmd_addr;
  logic [7:0]   mem_cmd_len;
  logic [1:0]   mem_cmd_prot;
  logic         mem_wdata_valid;
  logic         mem_wdata_ready;
  logic [63:0]  mem_wdata;
  logic         mem_wdata_last;
  logic         mem_rdata_valid;
  logic         mem_rdata_ready;
  logic [63:0]  mem_rdata;
  logic         mem_rdata_last;
  logic         proto_err;
`ifdef LLC_MEM_BRIDGE_STATS_EN
  logic [15:0]  stat_rd_cnt;
  logic [15:0]  stat_wr_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int wbeats = 0;

  llc_mem_bridge dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_hwrite(llc_mem_req_hwrite), .llc_mem_req_hprot(llc_mem_req_hprot),
    .llc_mem_req_addr(llc_mem_req_addr), .llc_mem_req_line(llc_mem_req_line),
    .llc_mem_rsp_valid(llc_mem_rsp_valid), .llc_mem_rsp_ready(llc_mem_rsp_ready),
    .llc_mem_rsp_line(llc_mem_rsp_line),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len(mem_cmd_len), .mem_cmd_prot(mem_cmd_prot),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
    .mem_rdata(mem_rdata), .mem_rdata_last(mem_rdata_last),
`ifdef LLC_MEM_BRIDGE_STATS_EN
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
`endif
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wdata_valid && mem_wdata_ready) wbeats <= wbeats + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] prot, input logic [27:0] addr,
                       input logic [127:0] line);
    llc_mem_req_valid  = 1'b1;
    llc_mem_req_hwrite = wr;
    llc_mem_req_hprot  = prot;
    llc_mem_req_addr   = addr;
    llc_mem_req_line   = line;
    step();
    llc_mem_req_valid  = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    mem_rdata_valid = 1'b1;
    mem_rdata       = d;
    mem_rdata_last  = last;
    step();
    mem_rdata_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    llc_mem_req_valid = 0; llc_mem_req_hwrite = 0; llc_mem_req_hprot = 0;
    llc_mem_req_addr = 0; llc_mem_req_line = 0; llc_mem_rsp_ready = 0;
    mem_cmd_ready = 0; mem_wdata_ready = 0; mem_rdata_valid = 0;
    mem_rdata = 0; mem_rdata_last = 0;
    step(); step();
    rst = 1'b0;

    check("rst_req_ready", llc_mem_req_ready, 1);
    check("rst_cmd_valid", mem_cmd_valid, 0);
    check("rst_wdata_valid", mem_wdata_valid, 0);
    check("rst_rsp_valid", llc_mem_rsp_valid, 0);
    check("rst_rdata_ready", mem_rdata_ready, 0);
    check("rst_proto_err", proto_err, 0);

    // Plain read
    issue(1'b0, 2'b01, 28'h0123456, 128'h0);
    check("rd_cmd_valid", mem_cmd_valid, 1);
    check("rd_req_ready_busy", llc_mem_req_ready, 0);
    check("rd_cmd_addr", mem_cmd_addr, 32'h01234560);
    check("rd_cmd_len", mem_cmd_len, 8'd1);
    check("rd_cmd_write", mem_cmd_write, 0);
    check("rd_cmd_prot", mem_cmd_prot, 2'b01);
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    check("rd_rdata_ready", mem_rdata_ready, 1);
    check("rd_cmd_dropped", mem_cmd_valid, 0);
    beat(64'hAAAA_0000_0000_0001, 1'b0);
    check("rd_wait_beat1", llc_mem_rsp_valid, 0);
    beat(64'hBBBB_0000_0000_0002, 1'b1);
    check("rd_rsp_valid", llc_mem_rsp_valid, 1);
    check("rd_rsp_line", llc_mem_rsp_line, 128'hBBBB_0000_0000_0002_AAAA_0000_0000_0001);
    check("rd_proto_err", proto_err, 0);
    llc_mem_rsp_ready = 1'b1;
    step();
    llc_mem_rsp_ready = 1'b0;
    check("rd_done_rsp_valid", llc_mem_rsp_valid, 0);
    check("rd_done_req_ready", llc_mem_req_ready, 1);

    // Writeback with a stalled command and a toggling data ready
    wbeats = 0;
    issue(1'b1, 2'b11, 28'h0FEDCBA, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    for (int i = 0; i < 5; i++) begin
      check("wr_cmd_valid_hold", mem_cmd_valid, 1);
      check("wr_cmd_addr_hold", mem_cmd_addr, 32'hFEDCBA0);
      check("wr_cmd_write_hold", mem_cmd_write, 1);
      check("wr_cmd_prot_hold", mem_cmd_prot, 2'b11);
      step();
    end
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    check("wr_beat0_valid", mem_wdata_valid, 1);
    check("wr_beat0_data", mem_wdata, 64'h5555_6666_7777_8888);
    check("wr_beat0_last", mem_wdata_last, 0);
    mem_wdata_ready = 1'b1;
    step();
    mem_wdata_ready = 1'b0;
    check("wr_beat1_data", mem_wdata, 64'h1111_2222_3333_4444);
    check("wr_beat1_last", mem_wdata_last, 1);
    step();
    check("wr_beat1_hold_valid", mem_wdata_valid, 1);
    check("wr_beat1_hold_data", mem_wdata, 64'h1111_2222_3333_4444);
    check("wr_no_rsp", llc_mem_rsp_valid, 0);
    mem_wdata_ready = 1'b1;
    step();
    mem_wdata_ready = 1'b0;
    check("wr_done_valid", mem_wdata_valid, 0);
    check("wr_done_req_ready", llc_mem_req_ready, 1);
    check("wr_no_rsp_after", llc_mem_rsp_valid, 0);
    check("wr_beat_count", wbeats, 2);

    // Read with an early last marker, then a stalled response with a pending request
    issue(1'b0, 2'b00, 28'h0000010, 128'h0);
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    beat(64'h0000_0000_0000_00C0, 1'b1);
    check("early_last_still_reading", mem_rdata_ready, 1);
    check("early_last_no_rsp", llc_mem_rsp_valid, 0);
    check("early_last_proto_err", proto_err, 1);
    beat(64'h0000_0000_0000_00C1, 1'b1);
    check("early_last_rsp_line", llc_mem_rsp_line, 128'h0000_0000_0000_00C1_0000_0000_0000_00C0);
    llc_mem_req_valid  = 1'b1;
    llc_mem_req_hwrite = 1'b0;
    llc_mem_req_addr   = 28'h0000020;
    for (int i = 0; i < 3; i++) begin
      check("rsp_stall_req_ready", llc_mem_req_ready, 0);
      check("rsp_stall_valid", llc_mem_rsp_valid, 1);
      step();
    end
    llc_mem_rsp_ready = 1'b1;
    check("rsp_hs_req_ready", llc_mem_req_ready, 0);
    step();
    llc_mem_rsp_ready = 1'b0;
    check("after_rsp_req_ready", llc_mem_req_ready, 1);
    check("proto_err_sticky", proto_err, 1);
    step();
    llc_mem_req_valid = 1'b0;
    check("pending_req_accepted", mem_cmd_valid, 1);
    check("pending_req_addr", mem_cmd_addr, 32'h00000200);

    // Reset in the middle of a read burst
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    beat(64'h0000_0000_DEAD_BEEF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_req_ready", llc_mem_req_ready, 1);
    check("midrst_cmd_valid", mem_cmd_valid, 0);
    check("midrst_rdata_ready", mem_rdata_ready, 0);
    check("midrst_rsp_valid", llc_mem_rsp_valid, 0);
    check("midrst_wdata_valid", mem_wdata_valid, 0);
    check("midrst_proto_err", proto_err, 0);

    issue(1'b0, 2'b10, 28'hABCDEF0, 128'h0);
    check("post_rst_cmd_addr", mem_cmd_addr, 32'hABCDEF00);
    check("post_rst_cmd_prot", mem_cmd_prot, 2'b10);
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    beat(64'h0000_0000_0000_0001, 1'b0);
    beat(64'h0000_0000_0000_0002, 1'b1);
    check("post_rst_rsp_valid", llc_mem_rsp_valid, 1);
    check("post_rst_rsp_line", llc_mem_rsp_line, 128'h0000_0000_0000_0002_0000_0000_0000_0001);
    check("post_rst_proto_err", proto_err, 0);
    llc_mem_rsp_ready = 1'b1;
    step();
    llc_mem_rsp_ready = 1'b0;
    check("post_rst_idle", llc_mem_req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
